i2c_txn_arbiter: RTL and testbench

//  Shares one i2c_master transaction engine among N_REQ on-chip requesters.

---
 rtl/i2c_arb_pkg.sv | 24 ++
 rtl/i2c_txn_arbiter_rr_pick.sv | 36 +++
 rtl/i2c_txn_arbiter.sv | 143 ++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the i2c transaction arbiter: descriptor layout, FSM states, response codes.
package i2c_arb_pkg;

    typedef struct packed {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } i2c_txn_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam int TXN_W = $bits(i2c_txn_t);

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Round-robin picker: first set bit of eff_req at or after rr_ptr, wrapping.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  eff_req,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0] rot;
    int           off;
    int           sum;

    always_comb begin
        // rot[i] is the request sitting i positions after the pointer.
        rot = N'({eff_req, eff_req} >> rr_ptr);
        any = 1'b0;
        off = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = i;
            end
        end
        sum = int'(rr_ptr) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        gnt_idx = IW'(sum);
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_master engine; optional WAIT watchdog under I2C_ARB_TIMEOUT_EN.
//  state | meaning
//  IDLE  | pick next requester, latch its descriptor
//  ISSUE | pulse m_start
//  WAIT  | engine running, wait for m_done (or watchdog)
//  RESP  | pulse ack to winner with response, advance pointer
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*TXN_W-1:0] req_txn,
    output logic [N_REQ-1:0]       ack,
    output logic [7:0]             resp_rdata,
    output logic [1:0]             resp_err,
    output logic                   busy,
    output logic                   m_start,
    output logic [TXN_W-1:0]       m_txn,
    output logic                   m_abort,
    input  logic                   m_done,
    input  logic [7:0]             m_rdata,
    input  logic                   m_nack
);

    localparam int IW = idx_width(N_REQ);

    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
        $error("i2c_txn_arbiter: N_REQ must be in 1..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("i2c_txn_arbiter: TIMEOUT_CYC must be in 1..65535");
    end

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    rr_ptr, winner, gnt_idx;
    logic [N_REQ-1:0] mask, eff_req;
    logic             any;
    logic             tmo_hit;

    assign eff_req = req & ~mask;

    rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
        .eff_req (eff_req),
        .rr_ptr  (rr_ptr),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    // wdog counts completed WAIT cycles, so the limit is hit on WAIT cycle TIMEOUT_CYC.
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wdog;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == ISSUE) begin
            wdog <= '0;
        end else if (state == WAIT) begin
            wdog <= wdog + 16'd1;
        end
    end

    assign tmo_hit = (state == WAIT) && (wdog == WDOG_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        m_start   = 1'b0;
        m_abort   = 1'b0;
        ack       = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_start   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    m_abort   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ack[winner] = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            winner     <= '0;
            mask       <= '0;
            m_txn      <= '0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (any) begin
                        winner <= gnt_idx;
                        m_txn  <= req_txn[int'(gnt_idx)*TXN_W +: TXN_W];
                    end
                end
                WAIT: begin
                    // MSB of the descriptor is rnw.
                    if (m_done) begin
                        resp_rdata <= (m_txn[TXN_W-1] && !m_nack) ? m_rdata : 8'h00;
                        resp_err   <= m_nack ? ERR_NACK : ERR_OK;
                    end else if (tmo_hit) begin
                        resp_rdata <= 8'h00;
                        resp_err   <= ERR_TMO;
                    end
                end
                RESP: begin
                    rr_ptr <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    mask   <= N_REQ'(1) << winner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [95:0] req_txn;
    logic [3:0]  ack;
    logic [7:0]  resp_rdata;
    logic [1:0]  resp_err;
    logic        busy;
    logic        m_start;
    logic [23:0] m_txn;
    logic        m_abort;
    logic        m_done;
    logic [7:0]  m_rdata;
    logic        m_nack;

    int compared   = 0;
    int mismatched = 0;

    logic [23:0] txn_of [4];

    i2c_txn_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_txn    (req_txn),
        .ack        (ack),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .m_start    (m_start),
        .m_txn      (m_txn),
        .m_abort    (m_abort),
        .m_done     (m_done),
        .m_rdata    (m_rdata),
        .m_nack     (m_nack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input int i, input logic [23:0] t);
        txn_of[i] = t;
        req_txn[i*24 +: 24] = t;
    endtask

    task automatic pulse_reset();
        req  = 4'b0000;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    // Leaves the bench in the ISSUE cycle; an expired bound is counted as a failure.
    task automatic wait_start(input string tag);
        bit seen = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (m_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s start_timeout: m_start=0 for 20 cycles, want 1", tag);
        end
    endtask

    // From the ISSUE cycle: spend wait_cyc cycles in WAIT, pulse m_done, end in the RESP cycle.
    task automatic finish_txn(input int wait_cyc, input logic [7:0] rd, input logic nack);
        repeat (wait_cyc) tick();
        m_done  = 1'b1;
        m_rdata = rd;
        m_nack  = nack;
        tick();
        m_done  = 1'b0;
        m_rdata = 8'h00;
        m_nack  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL reset_ack: got %b want 0000", ack); end
        compared++; if (m_start !== 1'b0) begin mismatched++; $display("FAIL reset_m_start: got %b want 0", m_start); end
        compared++; if (m_abort !== 1'b0) begin mismatched++; $display("FAIL reset_m_abort: got %b want 0", m_abort); end
        compared++; if (m_txn !== 24'h0) begin mismatched++; $display("FAIL reset_m_txn: got %h want 000000", m_txn); end
        compared++; if (resp_rdata !== 8'h00 || resp_err !== 2'b00) begin mismatched++; $display("FAIL reset_resp: got %h/%b want 00/00", resp_rdata, resp_err); end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        pulse_reset();
        set_txn(0, 24'h4801A5);
        req = 4'b0001;
        tick();
        compared++; if (m_start !== 1'b1) begin mismatched++; $display("FAIL t1_start_latency: m_start=%b want 1", m_start); end
        compared++; if (m_txn !== 24'h4801A5) begin mismatched++; $display("FAIL t1_m_txn: got %h want 4801a5", m_txn); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL t1_busy: got %b want 1", busy); end
        tick();
        compared++; if (m_start !== 1'b0) begin mismatched++; $display("FAIL t1_start_width: m_start=%b want 0", m_start); end
        finish_txn(9, 8'hFF, 1'b0);
        compared++; if (ack !== 4'b0001) begin mismatched++; $display("FAIL t1_ack: got %b want 0001", ack); end
        compared++; if (resp_err !== 2'b00) begin mismatched++; $display("FAIL t1_err: got %b want 00", resp_err); end
        compared++; if (resp_rdata !== 8'h00) begin mismatched++; $display("FAIL t1_rdata: got %h want 00", resp_rdata); end
        req[0] = 1'b0;
        tick();
        compared++; if (ack !== 4'b0000 || busy !== 1'b0) begin mismatched++; $display("FAIL t1_after: ack=%b busy=%b want 0000/0", ack, busy); end
    endtask

    task automatic test_read_nack();
        pulse_reset();
        set_txn(2, 24'hD01000);
        req = 4'b0100;
        wait_start("t2");
        compared++; if (m_txn !== 24'hD01000) begin mismatched++; $display("FAIL t2_m_txn: got %h want d01000", m_txn); end
        finish_txn(3, 8'h3C, 1'b1);
        compared++; if (ack !== 4'b0100) begin mismatched++; $display("FAIL t2_ack: got %b want 0100", ack); end
        compared++; if (resp_err !== 2'b01) begin mismatched++; $display("FAIL t2_err: got %b want 01", resp_err); end
        compared++; if (resp_rdata !== 8'h00) begin mismatched++; $display("FAIL t2_rdata: got %h want 00", resp_rdata); end
        req[2] = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        pulse_reset();
        for (int i = 0; i < 4; i++) set_txn(i, {8'(i), 16'($urandom)});
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_start("t3");
            compared++; if (m_txn !== txn_of[k]) begin mismatched++; $display("FAIL t3_grant[%0d]: m_txn=%h want %h", k, m_txn, txn_of[k]); end
            finish_txn(2, 8'h00, 1'b0);
            compared++; if (ack !== 4'(1 << k)) begin mismatched++; $display("FAIL t3_ack[%0d]: got %b want %b", k, ack, 4'(1 << k)); end
            req[k] = 1'b0;
        end
        tick();
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL t3_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_mask();
        pulse_reset();
        set_txn(1, 24'h221100);
        set_txn(3, 24'hA63377);
        req = 4'b0010;
        wait_start("t4a");
        req[3] = 1'b1;
        finish_txn(2, 8'h00, 1'b0);
        compared++; if (ack !== 4'b0010) begin mismatched++; $display("FAIL t4_ack1: got %b want 0010", ack); end
        tick();
        wait_start("t4b");
        req[1] = 1'b0;
        compared++; if (m_txn !== 24'hA63377) begin mismatched++; $display("FAIL t4_masked_grant: m_txn=%h want a63377", m_txn); end
        finish_txn(1, 8'h00, 1'b0);
        compared++; if (ack !== 4'b1000) begin mismatched++; $display("FAIL t4_ack3: got %b want 1000", ack); end
        req[3] = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        pulse_reset();
        set_txn(0, 24'h480042);
        set_txn(2, 24'h4A0011);
        set_txn(3, 24'hCC0F00);
        req = 4'b0100;
        wait_start("t5a");
        finish_txn(1, 8'h00, 1'b0);
        req[2] = 1'b0;
        req[3] = 1'b1;
        wait_start("t5b");
        tick();
        req[0] = 1'b1;
        rst    = 1'b1;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL t5_busy: got %b want 0", busy); end
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL t5_ack: got %b want 0000", ack); end
        compared++; if (m_txn !== 24'h0) begin mismatched++; $display("FAIL t5_m_txn: got %h want 000000", m_txn); end
        compared++; if (m_abort !== 1'b0) begin mismatched++; $display("FAIL t5_abort: got %b want 0", m_abort); end
        rst = 1'b0;
        wait_start("t5c");
        compared++; if (m_txn !== 24'h480042) begin mismatched++; $display("FAIL t5_first_grant: m_txn=%h want 480042", m_txn); end
        finish_txn(1, 8'h00, 1'b0);
        compared++; if (ack !== 4'b0001) begin mismatched++; $display("FAIL t5_ack0: got %b want 0001", ack); end
        req[0] = 1'b0;
        wait_start("t5d");
        finish_txn(1, 8'h00, 1'b0);
        compared++; if (ack !== 4'b1000) begin mismatched++; $display("FAIL t5_ack3: got %b want 1000", ack); end
        req[3] = 1'b0;
        tick();
    endtask

    // Model: grant goes to the first pending requester at or after the pointer; pointer moves past the winner.
    task automatic test_random();
        int          ptr = 0;
        int          exp;
        logic [7:0]  rd;
        logic        nack;
        logic [7:0]  exp_rd;
        pulse_reset();
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] == 1'b0 && $urandom_range(0, 1) == 1) begin
                    set_txn(i, 24'($urandom));
                    req[i] = 1'b1;
                end
            end
            if (req == 4'b0000) begin
                exp = $urandom_range(0, 3);
                set_txn(exp, 24'($urandom));
                req[exp] = 1'b1;
            end
            exp = -1;
            for (int k = 0; k < 4; k++) begin
                if (exp < 0 && req[(ptr + k) % 4]) exp = (ptr + k) % 4;
            end
            wait_start("rnd");
            compared++; if (m_txn !== txn_of[exp]) begin mismatched++; $display("FAIL rnd_txn[%0d]: m_txn=%h want %h", it, m_txn, txn_of[exp]); end
            rd     = 8'($urandom);
            nack   = ($urandom_range(0, 3) == 0);
            exp_rd = (txn_of[exp][23] && !nack) ? rd : 8'h00;
            finish_txn($urandom_range(1, 6), rd, nack);
            compared++; if (ack !== 4'(1 << exp)) begin mismatched++; $display("FAIL rnd_ack[%0d]: got %b want %b", it, ack, 4'(1 << exp)); end
            compared++; if (resp_rdata !== exp_rd) begin mismatched++; $display("FAIL rnd_rdata[%0d]: got %h want %h", it, resp_rdata, exp_rd); end
            compared++; if (resp_err !== {1'b0, nack}) begin mismatched++; $display("FAIL rnd_err[%0d]: got %b want %b", it, resp_err, {1'b0, nack}); end
            req[exp] = 1'b0;
            ptr = (exp + 1) % 4;
        end
        req = 4'b0000;
        tick();
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        pulse_reset();
        set_txn(0, 24'hC80155);
        req = 4'b0001;
        wait_start("t6a");
        for (int k = 1; k <= 16; k++) begin
            tick();
            compared++; if (m_abort !== (k == 16)) begin mismatched++; $display("FAIL t6_abort_cycle[%0d]: m_abort=%b want %b", k, m_abort, (k == 16)); end
        end
        m_rdata = 8'h77;
        tick();
        m_rdata = 8'h00;
        compared++; if (ack !== 4'b0001) begin mismatched++; $display("FAIL t6_ack: got %b want 0001", ack); end
        compared++; if (resp_err !== 2'b10) begin mismatched++; $display("FAIL t6_err: got %b want 10", resp_err); end
        compared++; if (resp_rdata !== 8'h00) begin mismatched++; $display("FAIL t6_rdata: got %h want 00", resp_rdata); end
        req[0] = 1'b0;
        tick();
        req = 4'b0001;
        wait_start("t6b");
        repeat (16) tick();
        m_done  = 1'b1;
        m_rdata = 8'h5A;
        #1;
        compared++; if (m_abort !== 1'b0) begin mismatched++; $display("FAIL t6_coincide_abort: got %b want 0", m_abort); end
        tick();
        m_done  = 1'b0;
        m_rdata = 8'h00;
        compared++; if (ack !== 4'b0001) begin mismatched++; $display("FAIL t6_coincide_ack: got %b want 0001", ack); end
        compared++; if (resp_err !== 2'b00) begin mismatched++; $display("FAIL t6_coincide_err: got %b want 00", resp_err); end
        compared++; if (resp_rdata !== 8'h5A) begin mismatched++; $display("FAIL t6_coincide_rdata: got %h want 5a", resp_rdata); end
        req[0] = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        pulse_reset();
        set_txn(1, 24'h900000);
        req = 4'b0010;
        wait_start("nt");
        for (int k = 1; k <= 40; k++) begin
            tick();
            compared++; if (m_abort !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin mismatched++; $display("FAIL nt_wait[%0d]: abort=%b ack=%b busy=%b want 0/0000/1", k, m_abort, ack, busy); end
        end
        finish_txn(1, 8'hE1, 1'b0);
        compared++; if (ack !== 4'b0010 || resp_err !== 2'b00 || resp_rdata !== 8'hE1) begin mismatched++; $display("FAIL nt_resp: ack=%b err=%b rdata=%h want 0010/00/e1", ack, resp_err, resp_rdata); end
        req[1] = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        req     = 4'b0000;
        req_txn = '0;
        m_done  = 1'b0;
        m_rdata = 8'h00;
        m_nack  = 1'b0;
        for (int i = 0; i < 4; i++) txn_of[i] = 24'h0;
        test_reset();
        test_single_write();
        test_read_nack();
        test_fairness();
        test_mask();
        test_reset_in_wait();
        test_random();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
